onchip_memory_arbiter: RTL and testbench
========================================

ONCHIP_MEMORY_ARBITER -- requirements
Module: onchip_memory_arbiter

Interface
REQ-001 SHALL provide parameter ADDR_W, default 14, word-address width of the shared memory.
REQ-002 SHALL provide parameter DATA_W, default 32, data width.
REQ-003 SHALL provide parameter BE_W, default 4, byteenable width (DATA_W/8).
REQ-004 SHALL provide port clk  in  1  single clock, rising-edge.
REQ-005 SHALL provide port reset  in  1  reset, asynchronous and active-high.
REQ-006 SHALL provide, for N in {0,1}: mN_address in ADDR_W; mN_byteenable in BE_W; mN_read in 1; mN_write in 1; mN_writedata in DATA_W (requester N command).
REQ-007 SHALL provide, for N in {0,1}: mN_waitrequest out 1 (command stalled); mN_readdata out DATA_W; mN_readdatavalid out 1 (read data returned).
REQ-008 SHALL provide memory-side ports mem_address out ADDR_W, mem_byteenable out BE_W, mem_chipselect out 1, mem_write out 1, mem_writedata out DATA_W, mem_clken out 1, mem_readdata in DATA_W.

Function
REQ-009 SHALL treat requester N as requesting when mN_read or mN_write is 1; simultaneous mN_read and mN_write SHALL be handled as a write only, with no readdatavalid.
REQ-010 SHALL grant at most one requester per cycle; grant is combinational from current requests and the registered last_grant pointer.
REQ-011 SHALL drive mem_* from the granted requester, mem_chipselect=1, mem_write=granted write; with no grant mem_chipselect=0, mem_write=0, other mem_* don't-care.
REQ-012 SHALL drive mem_clken=1 at all times outside reset and 0 while reset is asserted.
REQ-013 SHALL assert mN_waitrequest=1 when requester N requests and is not granted; 0 otherwise, including when idle.
REQ-014 SHALL accept a command in the cycle it is granted (waitrequest=0); each grant is one word; back-to-back grants to the same requester every cycle SHALL be allowed.
REQ-015 SHALL register a read-return tag {valid, owner}; for an accepted read, mOwner_readdatavalid=1 exactly one cycle after acceptance (memory output is unregistered, address registered).
REQ-016 SHALL drive mN_readdata=mem_readdata for both N; only the owning requester's readdatavalid is asserted.
REQ-017 SHALL sustain one read per cycle: a read accepted in cycle t and another in t+1 SHALL return in t+1 and t+2 with correct owners.
REQ-018 SHALL update last_grant to the granted requester on every granted cycle; unchanged when idle.
REQ-019 SHALL never assert both mem grants or both readdatavalid in one cycle.

Reset
REQ-020 SHALL, while reset=1: last_grant=1 (so m0 wins first contest), read tag valid=0, all waitrequest=0, all readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=0.
REQ-021 SHALL discard an in-flight read-return tag when reset asserts mid-operation; no readdatavalid after reset deassertion for pre-reset reads.
REQ-022 SHALL grant normally from the first clock edge after reset deassertion.

Configuration
REQ-023 SHALL honour macro ONCHIP_MEMORY_ARBITER_ROUND_ROBIN_EN: when defined, on contention the requester not equal to last_grant wins.
REQ-024 SHALL, without ONCHIP_MEMORY_ARBITER_ROUND_ROBIN_EN, use fixed priority: m0 always wins contention; last_grant register still maintained but unused for arbitration.

Verification
REQ-025 SHALL cover: after reset, m0 write addr 0x0010 data 0xDEADBEEF be 0xF, then m0 read 0x0010 -> m0_waitrequest=0 both cycles, m0_readdatavalid=1 one cycle after read with 0xDEADBEEF.
REQ-026 SHALL cover: m0 and m1 both read continuously 4 cycles, round-robin enabled -> grants alternate m0,m1,m0,m1; each readdatavalid one cycle after its grant; fixed-priority build -> m0 granted 4 cycles, m1_waitrequest=1 throughout.
REQ-027 SHALL cover: m0 write be 0x3 data 0x0000AAAA to addr 0x0020 preloaded 0x12345678, then read -> 0x1234AAAA.
REQ-028 SHALL cover: m1 read accepted, reset asserted next cycle before edge -> m1_readdatavalid stays 0, mem_chipselect=0, and after release m1 read of 0x0020 returns normally.
REQ-029 SHALL cover: m1 asserts read and write together to 0x0030 data 0x55AA55AA -> memory written, m1_readdatavalid stays 0; subsequent read returns 0x55AA55AA.

Source files
------------

// File: rtl/onchip_memory_arbiter.sv
// Two-requester arbiter onto a single on-chip memory port; grant is combinational, read data returns one cycle after acceptance.
// Build option: ONCHIP_MEMORY_ARBITER_ROUND_ROBIN_EN selects round-robin contention instead of fixed m0 priority.
module onchip_memory_arbiter #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32,
   parameter int BE_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);

   logic req0, req1;
   logic gnt0, gnt1;
   logic last_grant_q, last_grant_d;
   logic tag_vld_q, tag_vld_d;
   logic tag_own_q, tag_own_d;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         if (req0 && req1) begin
`ifdef ONCHIP_MEMORY_ARBITER_ROUND_ROBIN_EN
            // The requester that did not win last time takes the contended slot.
            gnt0 = last_grant_q;
            gnt1 = ~last_grant_q;
`else
            gnt0 = 1'b1;
`endif
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   assign mem_address    = gnt1 ? m1_address    : m0_address;
   assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
   assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
   assign mem_chipselect = gnt0 | gnt1;
   assign mem_write      = (gnt0 & m0_write) | (gnt1 & m1_write);
   assign mem_clken      = ~reset;

   assign m0_waitrequest = req0 & ~gnt0 & ~reset;
   assign m1_waitrequest = req1 & ~gnt1 & ~reset;

   always_comb begin
      last_grant_d = last_grant_q;
      if (gnt0 || gnt1) begin
         last_grant_d = gnt1;
      end
      // A combined read+write is a write only, so it never produces a return.
      tag_vld_d = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);
      tag_own_d = gnt1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= 1'b1;
         tag_vld_q    <= 1'b0;
         tag_own_q    <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         tag_vld_q    <= tag_vld_d;
         tag_own_q    <= tag_own_d;
      end
   end

   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = tag_vld_q & ~tag_own_q;
   assign m1_readdatavalid = tag_vld_q & tag_own_q;

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Bench for onchip_memory_arbiter: behavioural memory, reference model checked every cycle, directed scenarios.
module tb_onchip_memory_arbiter;
`ifdef ONCHIP_MEMORY_ARBITER_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   localparam int DEPTH = 16384;

   logic        clk;
   logic        reset;
   logic [13:0] m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [13:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_writedata, mem_readdata;

   int n_tests = 0;
   int n_fail  = 0;

   onchip_memory_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // Memory environment: address registered on clken, output unregistered.
   logic [31:0] env_mem [0:DEPTH-1];
   logic [13:0] env_addr_q;
   assign mem_readdata = env_mem[env_addr_q];

   always @(posedge clk) begin
      if (mem_clken) begin
         env_addr_q <= mem_address;
         if (mem_chipselect && mem_write)
            env_mem[mem_address] <= merge(env_mem[mem_address], mem_writedata, mem_byteenable);
      end
   end

   // Reference model
   logic [31:0] ref_mem [0:DEPTH-1];
   int          mdl_last;
   bit          pend_vld;
   int          pend_own;
   logic [31:0] pend_dat;

   always @(negedge clk) begin
      bit r0, r1, any, wrw, rdw;
      int win;
      logic [13:0] wa;
      logic [31:0] wd;
      logic [3:0]  wb;
      if (reset) begin
         chk("rst_wait0", m0_waitrequest, 0);
         chk("rst_wait1", m1_waitrequest, 0);
         chk("rst_rdv0", m0_readdatavalid, 0);
         chk("rst_rdv1", m1_readdatavalid, 0);
         chk("rst_cs", mem_chipselect, 0);
         chk("rst_wr", mem_write, 0);
         chk("rst_clken", mem_clken, 0);
         mdl_last = 1;
         pend_vld = 0;
      end else begin
         r0  = m0_read | m0_write;
         r1  = m1_read | m1_write;
         any = r0 | r1;
         if (r0 && r1) win = RR ? ((mdl_last == 0) ? 1 : 0) : 0;
         else          win = r1 ? 1 : 0;
         wrw = (win == 1) ? m1_write : m0_write;
         rdw = (win == 1) ? m1_read  : m0_read;
         wa  = (win == 1) ? m1_address : m0_address;
         wd  = (win == 1) ? m1_writedata : m0_writedata;
         wb  = (win == 1) ? m1_byteenable : m0_byteenable;

         chk("rdv0", m0_readdatavalid, pend_vld && pend_own == 0);
         chk("rdv1", m1_readdatavalid, pend_vld && pend_own == 1);
         if (pend_vld) chk("rdata", (pend_own == 1) ? m1_readdata : m0_readdata, pend_dat);
         chk("rdata0_pass", m0_readdata, mem_readdata);
         chk("rdata1_pass", m1_readdata, mem_readdata);
         chk("wait0", m0_waitrequest, r0 && !(any && win == 0));
         chk("wait1", m1_waitrequest, r1 && !(any && win == 1));
         chk("cs", mem_chipselect, any);
         chk("mem_wr", mem_write, any && wrw);
         chk("clken", mem_clken, 1);
         if (any) chk("mem_addr", mem_address, wa);
         if (any && wrw) begin
            chk("mem_wdata", mem_writedata, wd);
            chk("mem_be", mem_byteenable, wb);
         end

         pend_vld = any && rdw && !wrw;
         pend_own = win;
         pend_dat = ref_mem[wa];
         if (any && wrw) ref_mem[wa] = merge(ref_mem[wa], wd, wb);
         if (any) mdl_last = win;
      end
   end

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
   endtask

   task automatic set_m(input int n, input bit rd, input bit wr, input logic [13:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      if (n == 0) begin
         m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         env_mem[i] = 32'h0;
         ref_mem[i] = 32'h0;
      end
      env_mem[14'h0020] = 32'h12345678;
      ref_mem[14'h0020] = 32'h12345678;
      env_addr_q = '0;
      mdl_last = 1; pend_vld = 0; pend_own = 0; pend_dat = '0;
      reset = 1;
      m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
      m0_byteenable = '0; m1_byteenable = '0;
      idle();
      go(); go();
      reset = 0;
      go();

      // write then read back on m0
      set_m(0, 0, 1, 14'h0010, 32'hDEADBEEF, 4'hF);
      @(negedge clk); chk("wr_wait0", m0_waitrequest, 0);
      go();
      set_m(0, 1, 0, 14'h0010, 32'h0, 4'hF);
      @(negedge clk); chk("rd_wait0", m0_waitrequest, 0);
      go();
      idle();
      @(negedge clk);
      chk("rd_rdv0", m0_readdatavalid, 1);
      chk("rd_data0", m0_readdata, 32'hDEADBEEF);
      go();

      // contention, starting from a fresh last_grant
      reset = 1; go(); reset = 0;
      set_m(0, 1, 0, 14'h0010, 32'h0, 4'hF);
      set_m(1, 1, 0, 14'h0020, 32'h0, 4'hF);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("cont_wait1", m1_waitrequest, RR ? (k % 2 == 0) : 1);
         if (k > 0) begin
            chk("cont_rdv0", m0_readdatavalid, RR ? (k % 2 == 1) : 1);
            chk("cont_data", mem_readdata, (RR && k % 2 == 0) ? 32'h12345678 : 32'hDEADBEEF);
         end
         go();
      end
      idle();
      @(negedge clk);
      chk("cont_last_rdv1", m1_readdatavalid, RR);
      go();

      // partial byte-enable write over preloaded word
      set_m(0, 0, 1, 14'h0020, 32'h0000AAAA, 4'h3);
      go();
      set_m(0, 1, 0, 14'h0020, 32'h0, 4'hF);
      go();
      idle();
      @(negedge clk); chk("be_data", m0_readdata, 32'h1234AAAA);
      go();

      // reset with read return in flight
      set_m(1, 1, 0, 14'h0020, 32'h0, 4'hF);
      go();
      idle();
      reset = 1;
      @(negedge clk);
      chk("inflight_rdv1", m1_readdatavalid, 0);
      chk("inflight_cs", mem_chipselect, 0);
      go(); go();
      reset = 0;
      @(negedge clk); chk("post_rst_rdv1", m1_readdatavalid, 0);
      go();
      set_m(1, 1, 0, 14'h0020, 32'h0, 4'hF);
      @(negedge clk); chk("post_rst_wait1", m1_waitrequest, 0);
      go();
      idle();
      @(negedge clk);
      chk("post_rst_rdv1b", m1_readdatavalid, 1);
      chk("post_rst_data", m1_readdata, 32'h1234AAAA);
      go();

      // read+write together acts as a write
      set_m(1, 1, 1, 14'h0030, 32'h55AA55AA, 4'hF);
      go();
      idle();
      @(negedge clk); chk("rw_no_rdv1", m1_readdatavalid, 0);
      go();
      set_m(1, 1, 0, 14'h0030, 32'h0, 4'hF);
      go();
      idle();
      @(negedge clk); chk("rw_data", m1_readdata, 32'h55AA55AA);
      go();

      // mixed traffic on a small address window
      for (int i = 0; i < 32; i++) begin
         for (int n = 0; n < 2; n++) begin
            int op;
            op = $urandom_range(0, 3);
            set_m(n, op[0], op[1], 14'h0040 + 14'($urandom_range(0, 7)), $urandom,
                  4'($urandom_range(0, 15)));
         end
         go();
      end
      idle();
      go(); go();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
